// File: rtl/dev_intr_ctrl.sv
// dev_intr_ctrl: N-channel Unibus interrupt controller with per-channel handshake FSMs
// and a shared vector arbiter (fixed or round-robin priority).
module dev_intr_ctrl #(
    parameter int         NCH   = 2,
    parameter logic [8:0] VBASE = 9'o300,
    parameter int         VSTEP = 4,
    parameter int         RR    = 0,
    localparam int        SW    = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           vectREAD,
    input  logic [NCH-1:0] chIE,
    input  logic [NCH-1:0] chSET,
    input  logic [NCH-1:0] chDONE,
    output logic [NCH-1:0] chINTR,
    output logic           intr,
    output logic [8:0]     vector,
    output logic           vld,
    output logic [SW-1:0]  sel
);
    typedef enum logic [1:0] {C_IDLE, C_ACT, C_WAIT, C_DONE} ch_t;
    typedef enum logic [1:0] {A_IDLE, A_VREAD, A_VCLR, A_GRANT} arb_t;

    ch_t           ch_q [NCH];
    ch_t           ch_d [NCH];
    arb_t          arb_q, arb_d;
    logic [SW-1:0] sel_q, sel_d, ptr_q, ptr_d, base, cand;
    logic          vld_q, vld_d, better;
    logic [8:0]    vec_q, vec_d;
    logic [NCH-1:0] act, chclr;

    function automatic logic [SW-1:0] wrap(input int v);
        return SW'(v >= NCH ? v - NCH : v);
    endfunction

    // distance from the head of the priority order; smaller wins
    function automatic logic [SW-1:0] rank(input logic [SW-1:0] x, input logic [SW-1:0] b);
        return wrap(int'(x) + NCH - int'(b));
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign act[i]    = ch_q[i] == C_ACT;
        assign chINTR[i] = act[i] & chIE[i];
        assign chclr[i]  = arb_q == A_GRANT && sel_q == SW'(i);
    end

    assign intr   = |chINTR;
    assign base   = RR != 0 ? ptr_q : '0;
    assign better = rank(cand, base) < rank(sel_q, base);
    assign vld    = vld_q;
    assign sel    = sel_q;
    assign vector = vec_q;

    always_comb begin
        cand = base;
        for (int k = NCH - 1; k >= 0; k--)
            if (chINTR[wrap(int'(base) + k)]) cand = wrap(int'(base) + k);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_d[i] = ch_q[i];
            case (ch_q[i])
                C_IDLE:  if (chSET[i] && chIE[i]) ch_d[i] = C_ACT;
                C_ACT:   if (chclr[i]) ch_d[i] = C_WAIT;
                C_WAIT:  if (chDONE[i]) ch_d[i] = C_DONE;
                default: if (!chDONE[i]) ch_d[i] = C_IDLE;
            endcase
        end
    end

    always_comb begin
        arb_d = arb_q;
        sel_d = sel_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        case (arb_q)
            A_IDLE: if (|act) begin
                arb_d = A_VREAD;
                vld_d = 1'b0;
            end
            A_VREAD: begin
                if ((!vld_q || better) && intr) begin
                    sel_d = cand;
                    vld_d = 1'b1;
                end
                if (vectREAD) arb_d = A_VCLR;
            end
            A_VCLR: if (!vectREAD) arb_d = vld_q ? A_GRANT : A_IDLE;
            default: begin
                if (RR != 0) ptr_d = wrap(int'(sel_q) + 1);
                arb_d = A_IDLE;
            end
        endcase
        vec_d = 9'(int'(VBASE) + int'(sel_d) * VSTEP);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NCH; i++) ch_q[i] <= C_IDLE;
            arb_q <= A_IDLE;
            sel_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
            vec_q <= VBASE;
        end else begin
            ch_q  <= ch_d;
            arb_q <= arb_d;
            sel_q <= sel_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
            vec_q <= vec_d;
        end
    end
endmodule

// File: tb/tb_dev_intr_ctrl.sv
// tb_dev_intr_ctrl: two controllers (2-ch fixed, 4-ch round-robin) compared every cycle
// against an integer reference model, plus directed scenarios with literal expectations.
module tb_dev_intr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr0 = 1'b0, clr1 = 1'b0, vr0 = 1'b0, vr1 = 1'b0;
    logic [1:0] ie0 = '0, set0 = '0, done0 = '0;
    logic [3:0] ie1 = '0, set1 = '0, done1 = '0;
    logic [1:0] c0;
    logic [3:0] c1;
    logic i0, i1, v0, v1;
    logic [8:0] vec0, vec1;
    logic s0;
    logic [1:0] s1;
    int ncmp = 0, nbad = 0;

    always #5 clk = ~clk;

    dev_intr_ctrl #(.NCH(2), .VBASE(9'o300), .VSTEP(4), .RR(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr0), .vectREAD(vr0), .chIE(ie0), .chSET(set0),
        .chDONE(done0), .chINTR(c0), .intr(i0), .vector(vec0), .vld(v0), .sel(s0));
    dev_intr_ctrl #(.NCH(4), .VBASE(9'o300), .VSTEP(4), .RR(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr1), .vectREAD(vr1), .chIE(ie1), .chSET(set1),
        .chDONE(done1), .chINTR(c1), .intr(i1), .vector(vec1), .vld(v1), .sel(s1));

    // reference model: channel 0=idle 1=active 2=wait 3=done; phase 0=idle 1=read 2=clr 3=grant
    int NN [2] = '{2, 4};
    int RRM [2] = '{0, 1};
    int m_ch [2][4];
    int m_ph [2], m_sel [2], m_vld [2], m_ptr [2];

    function automatic int prio(int u, int c);
        return RRM[u] != 0 ? (c - m_ptr[u] + NN[u]) % NN[u] : c;
    endfunction

    function automatic int mint(int u, int ie);
        int r = 0;
        for (int c = 0; c < NN[u]; c++)
            if (m_ch[u][c] == 1 && ((ie >> c) & 1) != 0) r |= 1 << c;
        return r;
    endfunction

    task automatic model_step(int u, int ie, int st, int dn, int vr, int cl);
        int req, cand, busy;
        if (rst || cl != 0) begin
            for (int c = 0; c < 4; c++) m_ch[u][c] = 0;
            m_ph[u] = 0; m_sel[u] = 0; m_vld[u] = 0; m_ptr[u] = 0;
            return;
        end
        req = mint(u, ie);
        busy = 0;
        cand = -1;
        for (int c = 0; c < NN[u]; c++) begin
            if (m_ch[u][c] == 1) busy = 1;
            if (((req >> c) & 1) != 0 && (cand < 0 || prio(u, c) < prio(u, cand))) cand = c;
        end
        for (int c = 0; c < NN[u]; c++) begin
            case (m_ch[u][c])
                0: if (((st >> c) & 1) != 0 && ((ie >> c) & 1) != 0) m_ch[u][c] = 1;
                1: if (m_ph[u] == 3 && m_sel[u] == c) m_ch[u][c] = 2;
                2: if (((dn >> c) & 1) != 0) m_ch[u][c] = 3;
                default: if (((dn >> c) & 1) == 0) m_ch[u][c] = 0;
            endcase
        end
        case (m_ph[u])
            0: if (busy != 0) begin m_ph[u] = 1; m_vld[u] = 0; end
            1: begin
                if (cand >= 0 && (m_vld[u] == 0 || prio(u, cand) < prio(u, m_sel[u]))) begin
                    m_sel[u] = cand;
                    m_vld[u] = 1;
                end
                if (vr != 0) m_ph[u] = 2;
            end
            2: if (vr == 0) m_ph[u] = m_vld[u] != 0 ? 3 : 0;
            default: begin
                if (RRM[u] != 0) m_ptr[u] = (m_sel[u] + 1) % NN[u];
                m_ph[u] = 0;
            end
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d (0o%0o) expected %0d (0o%0o) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare();
        chk("u0.chINTR", int'(c0), mint(0, int'(ie0)));
        chk("u0.intr", int'(i0), int'(mint(0, int'(ie0)) != 0));
        chk("u0.vld", int'(v0), m_vld[0]);
        chk("u0.sel", int'(s0), m_sel[0]);
        chk("u0.vector", int'(vec0), (9'o300 + 4 * m_sel[0]) % 512);
        chk("u1.chINTR", int'(c1), mint(1, int'(ie1)));
        chk("u1.intr", int'(i1), int'(mint(1, int'(ie1)) != 0));
        chk("u1.vld", int'(v1), m_vld[1]);
        chk("u1.sel", int'(s1), m_sel[1]);
        chk("u1.vector", int'(vec1), (9'o300 + 4 * m_sel[1]) % 512);
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step(0, int'(ie0), int'(set0), int'(done0), int'(vr0), int'(clr0));
            model_step(1, int'(ie1), int'(set1), int'(done1), int'(vr1), int'(clr1));
            @(negedge clk);
            compare();
        end
    endtask

    task automatic clear0();
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        ie0 = '0; set0 = '0; done0 = '0; vr0 = 1'b0;
    endtask

    task automatic clear1();
        clr1 = 1'b1; tick(); clr1 = 1'b0;
        ie1 = '0; set1 = '0; done1 = '0; vr1 = 1'b0;
    endtask

    logic [8:0] rrvec [5];

    initial begin
        rrvec = '{9'o300, 9'o304, 9'o310, 9'o314, 9'o300};
        tick(2);
        rst = 1'b0;
        chk("rst.vector", int'(vec0), 9'o300);
        chk("rst.vld", int'(v0), 0);
        chk("rst.sel", int'(s1), 0);

        // higher-priority request pre-empts a commitment before vectREAD
        ie0 = 2'b11; set0 = 2'b10; tick(2);
        set0 = 2'b11; tick(3);
        vr0 = 1'b1; set0 = 2'b00; tick();
        chk("t1.vector", int'(vec0), 9'o300);
        chk("t1.sel", int'(s0), 0);
        vr0 = 1'b0; tick(2);
        chk("t1.chINTR", int'(c0), 2'b10);
        tick(2);
        chk("t1.vector2", int'(vec0), 9'o304);
        chk("t1.vld2", int'(v0), 1);
        clear0();

        // a request arriving after vectREAD does not displace the commitment
        ie0 = 2'b11; set0 = 2'b10; tick(3);
        vr0 = 1'b1; set0 = 2'b11; tick();
        chk("t2.vector", int'(vec0), 9'o304);
        tick();
        chk("t2.vector_hold", int'(vec0), 9'o304);
        vr0 = 1'b0; set0 = 2'b00; tick(2);
        chk("t2.chINTR", int'(c0), 2'b01);
        tick(2);
        chk("t2.vector2", int'(vec0), 9'o300);
        clear0();

        // masked active channel: passive release, then re-asserts on enable
        ie0 = 2'b01; set0 = 2'b01; tick();
        ie0 = 2'b00; set0 = 2'b00; tick(2);
        chk("t4.intr", int'(i0), 0);
        vr0 = 1'b1; tick();
        chk("t4.vld", int'(v0), 0);
        vr0 = 1'b0; tick(2);
        ie0 = 2'b01; tick();
        chk("t4.reassert", int'(c0), 2'b01);
        clear0();

        // clr during vector clear phase drops the commitment
        ie1 = 4'hf; set1 = 4'b0100; tick(4);
        vr1 = 1'b1; tick();
        chk("t5.sel", int'(s1), 2);
        chk("t5.vector", int'(vec1), 9'o310);
        clr1 = 1'b1; tick();
        chk("t5.vld", int'(v1), 0);
        chk("t5.vector_clr", int'(vec1), 9'o300);
        clr1 = 1'b0; vr1 = 1'b0; set1 = '0; tick(3);
        chk("t5.chINTR", int'(c1), 0);
        clear1();

        // round-robin rotation with re-arm through done
        ie1 = 4'hf; set1 = 4'hf;
        for (int r = 0; r < 5; r++) begin
            tick(4);
            vr1 = 1'b1; tick();
            chk("t3.sel", int'(s1), r % 4);
            chk("t3.vector", int'(vec1), int'(rrvec[r]));
            vr1 = 1'b0; tick(2);
            done1 = 4'hf; tick();
            done1 = 4'h0; tick(2);
        end
        clear1();

        // done held three cycles with set high
        ie0 = 2'b01; set0 = 2'b01; tick(4);
        vr0 = 1'b1; tick();
        vr0 = 1'b0; tick(2);
        chk("t6.wait", int'(c0), 0);
        done0 = 2'b01;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6.done", int'(c0), 0);
        end
        done0 = 2'b00; tick();
        chk("t6.idle", int'(c0), 0);
        tick();
        chk("t6.rearm", int'(c0), 2'b01);
        clear0();
        clear1();

        for (int n = 0; n < 4000; n++) begin
            rst   = $urandom % 400 == 0;
            clr0  = $urandom % 80 == 0;
            clr1  = $urandom % 80 == 0;
            ie0   = 2'($urandom | $urandom);
            ie1   = 4'($urandom | $urandom);
            set0  = 2'($urandom & $urandom);
            set1  = 4'($urandom & $urandom);
            done0 = 2'($urandom & $urandom);
            done1 = 4'($urandom & $urandom);
            if ($urandom % 5 == 0) vr0 = ~vr0;
            if ($urandom % 5 == 0) vr1 = ~vr1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
